env_intc: RTL and testbench

ENV_INTC -- requirements
Module: env_intc

---
 rtl/env_intc_pkg.sv | 25 ++
 rtl/env_intc_prio.sv | 20 ++
 rtl/env_intc.sv | 171 +++++++++++++++++
 tb/tb_env_intc.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/env_intc_pkg.sv
// Shared types and constants for the environment interrupt controller:
// FSM state, register offsets, status bit layout and the acknowledge vector format.
package env_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACK     = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

    localparam logic [1:0] REG_MASK   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_VEC    = 2'd2;

    localparam int STAT_PEND_LSB  = 0;
    localparam int STAT_INSVC_BIT = 5;
    localparam int STAT_SRC_LSB   = 6;

    // Vector byte presented on the data bus during an interrupt acknowledge.
    function automatic logic [7:0] ack_vector(input logic [4:0] vec_hi, input logic [1:0] src);
        return {vec_hi, src, 1'b0};
    endfunction

endpackage

// File: rtl/env_intc_prio.sv
// Fixed-priority encoder: lowest set index of the eligible vector wins.
module env_intc_prio (
    input  logic [3:0] eligible,
    output logic       valid,
    output logic [1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        // Scan downwards so the lowest set bit is the last (winning) assignment.
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) begin
                valid = 1'b1;
                idx   = 2'(i);
            end
        end
    end

endmodule

// File: rtl/env_intc.sv
// Single-level interrupt controller: edge-latched requests, mask, vectored
// acknowledge on the CPU bus, and an EOI-terminated service phase.
module env_intc
    import env_intc_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h90,
    parameter int         NUM_SRC   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic               m1_n,
    input  logic               iorq_n,
    input  logic               rd_n,
    input  logic               wr_n,
    input  logic [7:0]         addr,
    input  logic [7:0]         wr_data,
    output logic               int_n,
    output logic [7:0]         rd_data,
    output logic               dout_en
);

    state_t             state_q, state_d;
    logic               int_n_q, int_n_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [7:0]         vec_base_q, vec_base_d;
    logic [1:0]         cur_src_q, cur_src_d;
    logic [NUM_SRC-1:0] irq_prev_q;
    logic               wr_n_q;

    logic [NUM_SRC-1:0] irq_rise;
    logic [NUM_SRC-1:0] eligible;
    logic               win_valid;
    logic [1:0]         win_idx;
    logic [8:0]         addr_off;
    logic [1:0]         reg_off;
    logic               reg_sel;
    logic               ack_cycle;
    logic               ack_take;
    logic               wr_pulse;
    logic [7:0]         status;

    env_intc_prio u_prio (
        .eligible (eligible),
        .valid    (win_valid),
        .idx      (win_idx)
    );

    // 9-bit offset keeps addresses below the base (and any carry past 8'hFF) out of range.
    always_comb begin
        irq_rise  = irq_req & ~irq_prev_q;
        eligible  = pending_q & mask_q;
        addr_off  = {1'b0, addr} - {1'b0, BASE_ADDR};
        reg_off   = addr_off[1:0];
        reg_sel   = ~iorq_n & m1_n & (addr_off < 9'd3);
        ack_cycle = ~iorq_n & ~m1_n;
        ack_take  = (state_q == ST_REQ) & ack_cycle & win_valid;
        wr_pulse  = reg_sel & ~wr_n & wr_n_q;

        status = '0;
        status[STAT_SRC_LSB +: 2]        = cur_src_q;
        status[STAT_INSVC_BIT]           = (state_q == ST_SERVICE);
        status[STAT_PEND_LSB +: NUM_SRC] = pending_q;
    end

    always_comb begin
        state_d    = state_q;
        int_n_d    = int_n_q;
        cur_src_d  = cur_src_q;
        pending_d  = pending_q;
        mask_d     = mask_q;
        vec_base_d = vec_base_q;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_REQ;
                    int_n_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (ack_take) begin
                    state_d            = ST_ACK;
                    int_n_d            = 1'b1;
                    cur_src_d          = win_idx;
                    pending_d[win_idx] = 1'b0;
                end else if (!win_valid) begin
                    state_d = ST_IDLE;
                    int_n_d = 1'b1;
                end
            end
            ST_ACK: begin
                if (iorq_n) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (wr_pulse && reg_off == REG_STATUS) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // New edges are merged after the acknowledge clear so a same-cycle re-rise survives.
        pending_d = pending_d | irq_rise;

        if (wr_pulse) begin
            case (reg_off)
                REG_MASK: mask_d     = wr_data[NUM_SRC-1:0];
                REG_VEC:  vec_base_d = wr_data;
                default:  ;
            endcase
        end
    end

    // Data bus drive: acknowledge vector takes precedence over register reads.
    always_comb begin
        dout_en = 1'b0;
        rd_data = 8'h00;
        if (state_q == ST_ACK) begin
            dout_en = 1'b1;
            rd_data = ack_vector(vec_base_q[7:3], cur_src_q);
        end else if (ack_take) begin
            dout_en = 1'b1;
            rd_data = ack_vector(vec_base_q[7:3], win_idx);
        end else if (reg_sel && !rd_n) begin
            case (reg_off)
                REG_MASK: begin
                    dout_en = 1'b1;
                    rd_data = {{(8-NUM_SRC){1'b0}}, mask_q};
                end
                REG_STATUS: begin
                    dout_en = 1'b1;
                    rd_data = status;
                end
                REG_VEC: begin
                    dout_en = 1'b1;
                    rd_data = vec_base_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            int_n_q    <= 1'b1;
            pending_q  <= '0;
            mask_q     <= '0;
            vec_base_q <= 8'h00;
            cur_src_q  <= 2'd0;
            irq_prev_q <= '0;
            wr_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            int_n_q    <= int_n_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            vec_base_q <= vec_base_d;
            cur_src_q  <= cur_src_d;
            irq_prev_q <= irq_req;
            wr_n_q     <= wr_n;
        end
    end

    assign int_n = int_n_q;

endmodule

// File: tb/tb_env_intc.sv
// Self-checking bench for env_intc: register vector table plus hand-written
// interrupt sequences, with bus read data checked through an expectation queue.
module tb_env_intc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq_req = 4'h0;
    logic       m1_n = 1'b1;
    logic       iorq_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [7:0] addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       int_n;
    logic [7:0] rd_data;
    logic       dout_en;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       en;
        logic [7:0] data;
        string      name;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0] a;
        logic       do_wr;
        logic [7:0] wd;
        logic       exp_en;
        logic [7:0] exp_rd;
        string      name;
    } vec_t;
    vec_t vt[8];

    env_intc #(.BASE_ADDR(8'h90), .NUM_SRC(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_req (irq_req),
        .m1_n    (m1_n),
        .iorq_n  (iorq_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .addr    (addr),
        .wr_data (wr_data),
        .int_n   (int_n),
        .rd_data (rd_data),
        .dout_en (dout_en)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", name, act, exp);
        end else begin
            $display("ok   %s: 8'h%02h", name, act);
        end
    endtask

    task automatic sb_push(input logic en, input logic [7:0] data, input string name);
        exp_t e;
        e.en = en;
        e.data = data;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: queue empty, got en=%0b data=8'h%02h", dout_en, rd_data);
        end else begin
            e = sb_q.pop_front();
            chk({e.name, ".dout_en"}, {7'd0, dout_en}, {7'd0, e.en});
            chk({e.name, ".rd_data"}, rd_data, e.data);
        end
    endtask

    task automatic idle_bus();
        m1_n = 1'b1;
        iorq_n = 1'b1;
        rd_n = 1'b1;
        wr_n = 1'b1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        addr = a;
        wr_data = d;
        iorq_n = 1'b0;
        wr_n = 1'b0;
        tick();
        idle_bus();
        tick();
    endtask

    task automatic io_read(input logic [7:0] a, input logic en, input logic [7:0] exp, input string name);
        addr = a;
        iorq_n = 1'b0;
        rd_n = 1'b0;
        sb_push(en, exp, name);
        #1;
        sb_check();
        tick();
        idle_bus();
    endtask

    task automatic int_ack(input logic [7:0] exp, input string name);
        m1_n = 1'b0;
        iorq_n = 1'b0;
        sb_push(1'b1, exp, {name, ".first"});
        #1;
        sb_check();
        tick();
        sb_push(1'b1, exp, {name, ".held"});
        sb_check();
        chk({name, ".int_n_after_ack"}, {7'd0, int_n}, 8'd1);
        idle_bus();
        tick();
        chk({name, ".dout_en_service"}, {7'd0, dout_en}, 8'd0);
    endtask

    task automatic wait_int_low(input string name);
        int cnt = 0;
        while (int_n !== 1'b0 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({name, ".int_n_asserts"}, {7'd0, int_n}, 8'd0);
    endtask

    task automatic do_reset();
        idle_bus();
        irq_req = 4'h0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic setup(input logic [7:0] mask, input logic [7:0] vec);
        io_write(8'h92, vec);
        io_write(8'h90, mask);
    endtask

    initial begin
        vt[0] = '{8'h90, 1'b1, 8'hA5, 1'b1, 8'h05, "mask_wr_upper0"};
        vt[1] = '{8'h92, 1'b1, 8'h48, 1'b1, 8'h48, "vec_wr"};
        vt[2] = '{8'h91, 1'b0, 8'h00, 1'b1, 8'h00, "status_idle"};
        vt[3] = '{8'h93, 1'b1, 8'hFF, 1'b0, 8'h00, "above_range"};
        vt[4] = '{8'h8F, 1'b1, 8'hFF, 1'b0, 8'h00, "below_range"};
        vt[5] = '{8'h90, 1'b0, 8'h00, 1'b1, 8'h05, "mask_unchanged"};
        vt[6] = '{8'h92, 1'b0, 8'h00, 1'b1, 8'h48, "vec_unchanged"};
        vt[7] = '{8'h90, 1'b1, 8'h00, 1'b1, 8'h00, "mask_clear"};

        do_reset();
        chk("reset.int_n", {7'd0, int_n}, 8'd1);
        chk("reset.dout_en", {7'd0, dout_en}, 8'd0);
        chk("reset.rd_data", rd_data, 8'h00);
        m1_n = 1'b0;
        iorq_n = 1'b0;
        #1;
        chk("idle_ack_ignored.dout_en", {7'd0, dout_en}, 8'd0);
        tick();
        idle_bus();
        tick();

        for (int i = 0; i < 8; i++) begin
            if (vt[i].do_wr) io_write(vt[i].a, vt[i].wd);
            io_read(vt[i].a, vt[i].exp_en, vt[i].exp_rd, vt[i].name);
        end

        // Write held low across two edges: only the first edge updates.
        addr = 8'h92;
        wr_data = 8'h11;
        iorq_n = 1'b0;
        wr_n = 1'b0;
        tick();
        wr_data = 8'h22;
        tick();
        idle_bus();
        tick();
        io_read(8'h92, 1'b1, 8'h11, "single_update");

        // Single source 2
        do_reset();
        setup(8'h0F, 8'h40);
        irq_req[2] = 1'b1;
        tick();
        irq_req[2] = 1'b0;
        chk("src2.int_n_1cyc", {7'd0, int_n}, 8'd1);
        tick();
        chk("src2.int_n_2cyc", {7'd0, int_n}, 8'd0);
        int_ack(8'h44, "src2.ack");
        io_read(8'h91, 1'b1, 8'hA0, "src2.status");
        m1_n = 1'b0;
        iorq_n = 1'b0;
        #1;
        chk("service_ack_ignored.dout_en", {7'd0, dout_en}, 8'd0);
        tick();
        idle_bus();
        tick();
        io_write(8'h91, 8'h00);
        io_read(8'h91, 1'b1, 8'h80, "src2.status_after_eoi");

        // Simultaneous sources 3 and 1
        do_reset();
        setup(8'h0F, 8'h40);
        irq_req = 4'b1010;
        tick();
        irq_req = 4'b0000;
        wait_int_low("pair1");
        int_ack(8'h42, "pair.ack1");
        io_write(8'h91, 8'h00);
        wait_int_low("pair2");
        int_ack(8'h46, "pair.ack2");
        io_write(8'h91, 8'h00);

        // Masked source 0, then unmask
        do_reset();
        setup(8'h00, 8'h40);
        irq_req[0] = 1'b1;
        tick();
        irq_req[0] = 1'b0;
        tick();
        tick();
        chk("masked.int_n", {7'd0, int_n}, 8'd1);
        io_read(8'h91, 1'b1, 8'h01, "masked.status");
        addr = 8'h90;
        wr_data = 8'h01;
        iorq_n = 1'b0;
        wr_n = 1'b0;
        tick();
        chk("unmask.int_n_write_edge", {7'd0, int_n}, 8'd1);
        idle_bus();
        tick();
        chk("unmask.int_n_next", {7'd0, int_n}, 8'd0);

        // Withdraw in REQ by masking, EOI outside service
        io_write(8'h90, 8'h00);
        chk("withdraw.int_n", {7'd0, int_n}, 8'd1);
        io_read(8'h91, 1'b1, 8'h01, "withdraw.status");
        io_write(8'h91, 8'h00);
        io_read(8'h91, 1'b1, 8'h01, "stray_eoi.status");
        chk("stray_eoi.int_n", {7'd0, int_n}, 8'd1);
        io_write(8'h90, 8'h01);
        wait_int_low("remask");
        int_ack(8'h40, "remask.ack");
        io_write(8'h91, 8'h00);

        // Source 0 re-rises on the acknowledge edge
        do_reset();
        setup(8'h0F, 8'h40);
        irq_req[0] = 1'b1;
        tick();
        irq_req[0] = 1'b0;
        wait_int_low("rerise1");
        irq_req[0] = 1'b1;
        int_ack(8'h40, "rerise.ack1");
        irq_req[0] = 1'b0;
        io_read(8'h91, 1'b1, 8'h21, "rerise.status");
        io_write(8'h91, 8'h00);
        wait_int_low("rerise2");
        int_ack(8'h40, "rerise.ack2");
        io_write(8'h91, 8'h00);

        // Reset during acknowledge
        do_reset();
        setup(8'h0F, 8'h40);
        irq_req[1] = 1'b1;
        tick();
        irq_req[1] = 1'b0;
        wait_int_low("rst_ack");
        m1_n = 1'b0;
        iorq_n = 1'b0;
        tick();
        chk("rst_ack.dout_en_in_ack", {7'd0, dout_en}, 8'd1);
        reset = 1'b1;
        tick();
        chk("rst_ack.dout_en", {7'd0, dout_en}, 8'd0);
        chk("rst_ack.int_n", {7'd0, int_n}, 8'd1);
        chk("rst_ack.rd_data", rd_data, 8'h00);
        reset = 1'b0;
        idle_bus();
        tick();
        io_read(8'h91, 1'b1, 8'h00, "rst_ack.status");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
